response_matcher: RTL and testbench
===================================

Name: response_matcher

Overview:
- Parametrised line-oriented response classifier for the serial (GSM/BLE) command path.
- Once armed, it collects bytes from the UART receiver until a CR terminator arrives. It then compares the collected line against a fixed table of module responses ("OK", "OK+CONNA", "OK+CONNE", "OK+CONNF", "OK+CONNL").
- It reports a result code plus the 2-bit legacy error code, and holds them until acknowledged. A cycle timeout covers modules that never answer.
- It sits between the UART RX byte output and the command sequencer FSM.

Parameters:
- MAX_LEN, 16, maximum stored characters per line; must be >= 8.
- TIMEOUT_CYCLES, 50000000, clk cycles allowed in WAIT before a timeout result; must be >= 2.
- CR_CHAR, 8'h0D, line terminator.
- LF_CHAR, 8'h0A, character that is silently discarded.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  received byte; stable while data_ready is high.
- data_ready  input  1  byte strobe from UART RX, synchronous to clk; a byte is taken on its rising edge.
- start  input  1  one-cycle arm request from the sequencer.
- ack  input  1  one-cycle result acknowledge.
- busy  output  1  high in WAIT and COMPARE.
- result_valid  output  1  high in DONE.
- result  output  3  classification code, valid while result_valid is high.
- erro  output  2  legacy error code, valid while result_valid is high.

Behaviour:
- Reset (async, rst=1): state IDLE; buffer, len, overflow flag, timer, data_ready_q all cleared; busy=0, result_valid=0, result=3'd0, erro=2'b00.
- Byte strobe: data_ready_q registers data_ready each clk. A byte event occurs in a cycle where data_ready=1 and data_ready_q=0; data is sampled in that cycle.
  - Exactly one event per high pulse, regardless of pulse length.
  - Events outside WAIT are discarded.
- Buffer: MAX_LEN*8-bit shift register, newest byte in bits [7:0].
- len counter: width clog2(MAX_LEN+1); saturates at MAX_LEN.
- FSM states:
  - IDLE: start=1 -> WAIT. On entry, buffer, len, overflow flag and timer are cleared.
  - WAIT, timer: increments every cycle.
  - WAIT, byte event handling:
    - LF_CHAR: ignored.
    - CR_CHAR with len=0: ignored; covers the blank line of a CRLF pair.
    - CR_CHAR with len>0: -> COMPARE.
    - Any other byte with len<MAX_LEN: shifted in, len+1.
    - Any other byte with len=MAX_LEN: byte dropped, overflow flag set.
  - WAIT, timeout: timer = TIMEOUT_CYCLES-1 with no CR event in that cycle -> DONE with result=7. If a CR event and the timeout coincide, the CR event wins.
  - COMPARE: exactly one cycle, then -> DONE. A table entry of length L matches only if len=L and buffer[8L-1:0] equals the string (first character in the most significant byte). An overflowed line never matches.
  - DONE: result and erro held stable. ack=1 -> IDLE, with result_valid dropping on the next edge. start is ignored in DONE.
- start in WAIT or COMPARE is ignored; there is no restart mid-line.
- ack outside DONE is ignored.
- result codes: 0 none, 1 "OK", 2 "OK+CONNA", 3 "OK+CONNE", 4 "OK+CONNF", 5 "OK+CONNL", 6 unrecognised/overflow, 7 timeout.
- erro mapping:
  - CONNE, CONNL, timeout -> 2'b11.
  - CONNF -> 2'b10.
  - CONNA -> 2'b01.
  - OK, unrecognised -> 2'b00.
  - 2'b00 whenever result_valid=0.
- Latency: for a CR event sampled in cycle N, the state is COMPARE in cycle N+1 and result_valid is first high in cycle N+2.
- Reset mid-operation: returns immediately to reset values; any partial line is lost.
- Timer width: clog2(TIMEOUT_CYCLES); no wrap is possible because the timeout exits WAIT.

Test Plan:
- Reset, start, feed "OK+CONNA",CR,LF (each data_ready pulse 3 cycles) -> result_valid 2 cycles after the CR event, result=2, erro=01; ack -> IDLE, result_valid=0, erro=00.
- Start, feed CR,LF,"OK+CONNE",CR -> leading CR/LF ignored; result=3, erro=11. Repeat with "OK+CONNF" -> result=4, erro=10; with "OK",CR -> result=1, erro=00.
- MAX_LEN=8: start, feed "OK+CONNAX",CR -> overflow set, result=6, erro=00. Feed "OK+CONN",CR -> result=6 (length mismatch).
- TIMEOUT_CYCLES=100: start, no bytes -> result_valid at cycle 100 after WAIT entry, result=7, erro=11. Second run with CR event in cycle 99 after "OK+CONNL" -> result=5, not 7.
- Bytes pulsed while IDLE and in DONE, and a start pulse in WAIT -> no effect on buffer or state. A single data_ready held high for 20 cycles -> exactly one byte stored.
- Assert rst for 1 cycle after "OK+CO" in WAIT -> busy=0, result_valid=0, erro=00 immediately. A fresh start then "OK",CR -> result=1.

Source files
------------

// File: rtl/response_matcher.sv
// Line-oriented response classifier: collects UART RX bytes up to CR, then matches the line
// against the module response table. result/erro stay valid until ack (one-cycle pulse) is seen in DONE.
module response_matcher #(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0]  CR_CHAR        = 8'h0D,
    parameter logic [7:0]  LF_CHAR        = 8'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_ready,
    input  logic       start,
    input  logic       ack,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] result,
    output logic [1:0] erro
);
    localparam int BUF_W = MAX_LEN * 8;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [15:0] RSP_OK    = "OK";
    localparam logic [63:0] RSP_CONNA = "OK+CONNA";
    localparam logic [63:0] RSP_CONNE = "OK+CONNE";
    localparam logic [63:0] RSP_CONNF = "OK+CONNF";
    localparam logic [63:0] RSP_CONNL = "OK+CONNL";

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMPARE, S_DONE} state_t;

    state_t           state_q;
    logic [BUF_W-1:0] buf_q;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;
    logic [TMR_W-1:0] timer_q;
    logic             data_ready_q;
    logic             byte_ev;
    logic [2:0]       code_d;

    assign byte_ev = data_ready && !data_ready_q;

    function automatic logic [1:0] erro_of(input logic [2:0] code);
        case (code)
            3'd2:             erro_of = 2'b01;
            3'd4:             erro_of = 2'b10;
            3'd3, 3'd5, 3'd7: erro_of = 2'b11;
            default:          erro_of = 2'b00;
        endcase
    endfunction

    // Bytes above len are always zero (cleared on arm, never shifted on overflow),
    // so a whole-buffer compare against the zero-extended string plus the len check is exact.
    always_comb begin
        code_d = 3'd6;
        if (!ovf_q) begin
            if (len_q == LEN_W'(2) && buf_q == BUF_W'(RSP_OK)) begin
                code_d = 3'd1;
            end else if (len_q == LEN_W'(8)) begin
                if (buf_q == BUF_W'(RSP_CONNA))      code_d = 3'd2;
                else if (buf_q == BUF_W'(RSP_CONNE)) code_d = 3'd3;
                else if (buf_q == BUF_W'(RSP_CONNF)) code_d = 3'd4;
                else if (buf_q == BUF_W'(RSP_CONNL)) code_d = 3'd5;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            timer_q      <= '0;
            data_ready_q <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 3'd0;
            erro         <= 2'b00;
        end else begin
            data_ready_q <= data_ready;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_WAIT;
                        busy    <= 1'b1;
                        buf_q   <= '0;
                        len_q   <= '0;
                        ovf_q   <= 1'b0;
                        timer_q <= '0;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A terminating CR takes priority over a coincident timeout.
                    if (byte_ev && data == CR_CHAR && len_q != '0) begin
                        state_q <= S_COMPARE;
                    end else if (timer_q == TMR_LAST) begin
                        state_q      <= S_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        result       <= 3'd7;
                        erro         <= erro_of(3'd7);
                    end else if (byte_ev && data != LF_CHAR && data != CR_CHAR) begin
                        if (len_q == LEN_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            buf_q <= {buf_q[BUF_W-9:0], data};
                            len_q <= len_q + 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    state_q      <= S_DONE;
                    busy         <= 1'b0;
                    result_valid <= 1'b1;
                    result       <= code_d;
                    erro         <= erro_of(code_d);
                end
                S_DONE: begin
                    if (ack) begin
                        state_q      <= S_IDLE;
                        result_valid <= 1'b0;
                        result       <= 3'd0;
                        erro         <= 2'b00;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_response_matcher.sv
// Directed bench for response_matcher (MAX_LEN=8, TIMEOUT_CYCLES=100) with an expected-result queue.
module tb_response_matcher;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       data_ready;
    logic       start;
    logic       ack;
    logic       busy;
    logic       result_valid;
    logic [2:0] result;
    logic [1:0] erro;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [4:0] exp_q[$];   // {result, erro}

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    response_matcher #(
        .MAX_LEN       (8),
        .TIMEOUT_CYCLES(100),
        .CR_CHAR       (8'h0D),
        .LF_CHAR       (8'h0A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .data_ready  (data_ready),
        .start       (start),
        .ack         (ack),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .erro        (erro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi);
        data       = b;
        data_ready = 1'b1;
        repeat (hi) @(posedge clk);
        #1 data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    // CR event sampled at the first edge: COMPARE after it, DONE after the next.
    task automatic send_cr_check(input string tag);
        data       = CR;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " busy N+1"}, busy, 1);
        chk({tag, " valid N+1"}, result_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, " valid N+2"}, result_valid, 1);
        @(posedge clk);
        #1 data_ready = 1'b0;
    endtask

    task automatic check_result(input string tag);
        logic [4:0] e;
        int k = 0;
        while (!result_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " valid"}, result_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " result"}, result, e[4:2]);
            chk({tag, " erro"}, erro, e[1:0]);
        end
    endtask

    task automatic do_ack(input string tag);
        pulse_ack();
        chk({tag, " ack valid"}, result_valid, 0);
        chk({tag, " ack erro"}, erro, 0);
        chk({tag, " ack busy"}, busy, 0);
    endtask

    task automatic run_line(input string tag, input string s, input logic [2:0] r, input logic [1:0] er);
        pulse_start();
        chk({tag, " busy"}, busy, 1);
        exp_q.push_back({r, er});
        send_str(s);
        send_cr_check(tag);
        check_result(tag);
        do_ack(tag);
    endtask

    initial begin
        int k;
        int c0;
        rst        = 1'b1;
        data       = 8'h00;
        data_ready = 1'b0;
        start      = 1'b0;
        ack        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset valid", result_valid, 0);
        chk("reset result", result, 0);
        chk("reset erro", erro, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CONNA followed by a trailing LF that lands in DONE.
        pulse_start();
        exp_q.push_back({3'd2, 2'b01});
        send_str("OK+CONNA");
        send_cr_check("conna");
        check_result("conna");
        send_byte(LF, 3);
        chk("conna held valid", result_valid, 1);
        chk("conna held result", result, 2);
        do_ack("conna");

        // Leading CR/LF of a blank line are ignored.
        pulse_start();
        exp_q.push_back({3'd3, 2'b11});
        send_byte(CR, 3);
        send_byte(LF, 3);
        chk("blank cr busy", busy, 1);
        send_str("OK+CONNE");
        send_cr_check("conne");
        check_result("conne");
        do_ack("conne");

        run_line("connf", "OK+CONNF", 3'd4, 2'b10);
        run_line("ok", "OK", 3'd1, 2'b00);
        run_line("overflow", "OK+CONNAX", 3'd6, 2'b00);
        run_line("short", "OK+CONN", 3'd6, 2'b00);
        run_line("unknown", "ERROR", 3'd6, 2'b00);

        // Timeout with no bytes: first valid 100 cycles after WAIT entry.
        pulse_start();
        exp_q.push_back({3'd7, 2'b11});
        k = 0;
        while (!result_valid && k < 150) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("timeout latency", k, 100);
        check_result("timeout");
        do_ack("timeout");

        // CR event in cycle 99 beats the coincident timeout.
        pulse_start();
        c0 = cyc;
        exp_q.push_back({3'd5, 2'b11});
        send_str("OK+CONNL");
        while (cyc < c0 + 99) begin
            @(posedge clk);
            #1;
        end
        chk("connl pre-cr busy", busy, 1);
        send_cr_check("connl");
        check_result("connl");
        do_ack("connl");

        // Bytes in IDLE, start/ack in WAIT, bytes/start in DONE.
        send_byte("O", 3);
        send_byte("X", 3);
        chk("idle bytes busy", busy, 0);
        chk("idle bytes valid", result_valid, 0);
        pulse_start();
        exp_q.push_back({3'd1, 2'b00});
        send_byte("O", 3);
        pulse_start();
        pulse_ack();
        chk("wait start busy", busy, 1);
        send_byte("K", 3);
        send_cr_check("ignore");
        check_result("ignore");
        send_byte("Z", 3);
        pulse_start();
        chk("done start valid", result_valid, 1);
        chk("done start result", result, 1);
        chk("done start erro", erro, 0);
        do_ack("ignore");

        // Long strobe yields exactly one byte.
        pulse_start();
        exp_q.push_back({3'd1, 2'b00});
        send_byte("O", 20);
        send_byte("K", 3);
        send_cr_check("long strobe");
        check_result("long strobe");
        do_ack("long strobe");

        // Asynchronous reset mid-line.
        pulse_start();
        send_str("OK+CO");
        rst = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset valid", result_valid, 0);
        chk("midreset erro", erro, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_line("after reset", "OK", 3'd1, 2'b00);

        chk("queue drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
